// File: rtl/ram_seq_controller_if.sv
// Bundle of the game-FSM command bus, the sequence-RAM port and the
// sequencer status outputs. The sequencer takes the slave side; the game
// FSM together with the RAM sits on the master side.
interface ram_seq_controller_if;
  logic       cmd_clear;
  logic       cmd_append;
  logic       cmd_play;
  logic       cmd_check;
  logic [3:0] cmd_data;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [3:0] ram_din;
  logic [3:0] ram_dout;
  logic       busy;
  logic       done;
  logic [4:0] seq_len;
  logic       full;
  logic       play_valid;
  logic [3:0] play_data;
  logic       check_match;
  logic       check_miss;
  logic       check_complete;
  logic       error;

  modport slave (
    input  cmd_clear, cmd_append, cmd_play, cmd_check, cmd_data, ram_dout,
    output ram_we, ram_addr, ram_din, busy, done, seq_len, full,
           play_valid, play_data, check_match, check_miss, check_complete, error
  );

  modport master (
    output cmd_clear, cmd_append, cmd_play, cmd_check, cmd_data, ram_dout,
    input  ram_we, ram_addr, ram_din, busy, done, seq_len, full,
           play_valid, play_data, check_match, check_miss, check_complete, error
  );
endinterface

// File: rtl/ram_seq_controller.sv
// Sequencer for the 16x4 synchronous sequence RAM of the PULOdoSAPO game.
// Runs clear / append / play / check commands against the RAM, keeps the
// sequence length and the player's check position, and reports results.
// The RAM port decodes from registered state only; every status output is
// a register loaded from the next-state logic.
module ram_seq_controller #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  ram_seq_controller_if.slave  bus
);

  localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [4:0]       DEPTH     = 5'd16;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLEAR     = 4'd1,
    ST_APPEND    = 4'd2,
    ST_PLAY_READ = 4'd3,
    ST_PLAY_WAIT = 4'd4,
    ST_PLAY_HOLD = 4'd5,
    ST_CHK_READ  = 4'd6,
    ST_CHK_WAIT  = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          clr_cnt_r, clr_cnt_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [4:0]          play_idx_r, play_idx_s;
  logic [4:0]          check_idx_r, check_idx_s;
  logic [4:0]          seq_len_r, seq_len_s;
  logic [3:0]          data_r, data_s;
  logic [3:0]          play_data_r, play_data_s;
  logic                error_r, error_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                full_r, full_s;
  logic                play_valid_r, play_valid_s;
  logic                check_match_r, check_match_s;
  logic                check_miss_r, check_miss_s;
  logic                check_complete_r, check_complete_s;
  logic                ram_we_s;
  logic [3:0]          ram_addr_s;
  logic [3:0]          ram_din_s;

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      clr_cnt_r        <= 4'd0;
      hold_cnt_r       <= {HOLD_W{1'b0}};
      play_idx_r       <= 5'd0;
      check_idx_r      <= 5'd0;
      seq_len_r        <= 5'd0;
      data_r           <= 4'd0;
      play_data_r      <= 4'd0;
      error_r          <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      full_r           <= 1'b0;
      play_valid_r     <= 1'b0;
      check_match_r    <= 1'b0;
      check_miss_r     <= 1'b0;
      check_complete_r <= 1'b0;
    end else begin
      state_r          <= state_s;
      clr_cnt_r        <= clr_cnt_s;
      hold_cnt_r       <= hold_cnt_s;
      play_idx_r       <= play_idx_s;
      check_idx_r      <= check_idx_s;
      seq_len_r        <= seq_len_s;
      data_r           <= data_s;
      play_data_r      <= play_data_s;
      error_r          <= error_s;
      busy_r           <= busy_s;
      done_r           <= done_s;
      full_r           <= full_s;
      play_valid_r     <= play_valid_s;
      check_match_r    <= check_match_s;
      check_miss_r     <= check_miss_s;
      check_complete_r <= check_complete_s;
    end
  end

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_s          = state_r;
    clr_cnt_s        = clr_cnt_r;
    hold_cnt_s       = hold_cnt_r;
    play_idx_s       = play_idx_r;
    check_idx_s      = check_idx_r;
    seq_len_s        = seq_len_r;
    data_s           = data_r;
    play_data_s      = play_data_r;
    error_s          = error_r;
    play_valid_s     = 1'b0;
    check_match_s    = 1'b0;
    check_miss_s     = 1'b0;
    check_complete_s = 1'b0;

    case (state_r)
      // The done cycle accepts commands just like idle.
      ST_IDLE, ST_DONE: begin
        state_s = ST_IDLE;
        if (bus.cmd_clear) begin
          clr_cnt_s = 4'd0;
          state_s   = ST_CLEAR;
        end else if (bus.cmd_append) begin
          data_s = bus.cmd_data;
          if (seq_len_r == DEPTH) begin
            error_s = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_APPEND;
          end
        end else if (bus.cmd_check) begin
          data_s = bus.cmd_data;
          if (check_idx_r >= seq_len_r) begin
            error_s = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_CHK_READ;
          end
        end else if (bus.cmd_play) begin
          play_idx_s = 5'd0;
          if (seq_len_r == 5'd0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_PLAY_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (clr_cnt_r == 4'd15) begin
          seq_len_s   = 5'd0;
          check_idx_s = 5'd0;
          play_data_s = 4'd0;
          error_s     = 1'b0;
          state_s     = ST_DONE;
        end else begin
          clr_cnt_s = clr_cnt_r + 4'd1;
        end
      end

      ST_APPEND: begin
        seq_len_s   = seq_len_r + 5'd1;
        check_idx_s = 5'd0;
        state_s     = ST_DONE;
      end

      ST_PLAY_READ: begin
        state_s = ST_PLAY_WAIT;
      end

      // RAM output is valid here; capture it and flag the new entry.
      ST_PLAY_WAIT: begin
        play_data_s  = bus.ram_dout;
        play_valid_s = 1'b1;
        hold_cnt_s   = {HOLD_W{1'b0}};
        state_s      = ST_PLAY_HOLD;
      end

      ST_PLAY_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          if ((play_idx_r + 5'd1) == seq_len_r) begin
            state_s = ST_DONE;
          end else begin
            play_idx_s = play_idx_r + 5'd1;
            state_s    = ST_PLAY_READ;
          end
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end
      end

      ST_CHK_READ: begin
        state_s = ST_CHK_WAIT;
      end

      // Matching the final entry wraps the check position for a new round.
      ST_CHK_WAIT: begin
        if (bus.ram_dout == data_r) begin
          check_match_s = 1'b1;
          if ((check_idx_r + 5'd1) == seq_len_r) begin
            check_complete_s = 1'b1;
            check_idx_s      = 5'd0;
          end else begin
            check_idx_s = check_idx_r + 5'd1;
          end
        end else begin
          check_miss_s = 1'b1;
          check_idx_s  = 5'd0;
        end
        state_s = ST_DONE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE) && (state_s != ST_DONE);
    done_s = (state_s == ST_DONE);
    full_s = (seq_len_s == DEPTH);
  end

  // RAM port decode from the state registers; writes only in clear/append.
  always_comb begin
    ram_we_s   = 1'b0;
    ram_addr_s = 4'd0;
    ram_din_s  = 4'd0;
    case (state_r)
      ST_CLEAR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = clr_cnt_r;
      end
      ST_APPEND: begin
        ram_we_s   = 1'b1;
        ram_addr_s = seq_len_r[3:0];
        ram_din_s  = data_r;
      end
      ST_PLAY_READ, ST_PLAY_WAIT, ST_PLAY_HOLD: begin
        ram_addr_s = play_idx_r[3:0];
      end
      ST_CHK_READ, ST_CHK_WAIT: begin
        ram_addr_s = check_idx_r[3:0];
      end
      default: begin
        ram_addr_s = 4'd0;
      end
    endcase
  end

  assign bus.ram_we         = ram_we_s;
  assign bus.ram_addr       = ram_addr_s;
  assign bus.ram_din        = ram_din_s;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.seq_len        = seq_len_r;
  assign bus.full           = full_r;
  assign bus.play_valid     = play_valid_r;
  assign bus.play_data      = play_data_r;
  assign bus.check_match    = check_match_r;
  assign bus.check_miss     = check_miss_r;
  assign bus.check_complete = check_complete_r;
  assign bus.error          = error_r;

endmodule

// File: tb/tb_ram_seq_controller.sv
// Bench for ram_seq_controller: a 16x4 registered-read RAM model, a
// transaction-level model of the command rules that expands each command
// into expected per-cycle outputs, a per-cycle compare process, and a few
// hand-computed literal expectations.
module tb_ram_seq_controller;

  localparam int HOLD = 4;
  localparam int K_CLEAR  = 0;
  localparam int K_APPEND = 1;
  localparam int K_PLAY   = 2;
  localparam int K_CHECK  = 3;

  typedef struct {
    logic       busy;
    logic       we;
    logic       achk;
    logic [3:0] addr;
    logic [3:0] din;
    logic       done;
    logic       pv;
    logic [3:0] pd;
    logic       mt;
    logic       ms;
    logic       cp;
    logic [4:0] len;
    logic       err;
  } exp_t;

  logic clock;
  logic reset;
  ram_seq_controller_if bus();

  ram_seq_controller #(.HOLD_CYCLES(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   comp_cnt = 0;
  logic chk_en = 1'b0;
  exp_t exp_q[$];
  logic [3:0] pv_data_q[$];
  int   pv_cyc_q[$];

  // Model state: the logical sequence and the rule-level counters.
  logic [3:0] m_seq [16];
  int         m_len = 0;
  int         m_cidx = 0;
  logic [3:0] m_pd = 4'd0;
  logic       m_err = 1'b0;

  logic [3:0] mem [16];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sequence RAM: registered read, read-before-write, not cleared by reset.
  always @(posedge clock) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic busy, we, achk, input logic [3:0] addr, din,
                              input logic done, pv, input logic [3:0] pd,
                              input logic mt, ms, cp, input int len, input logic err);
    exp_t e;
    e.busy = busy; e.we = we; e.achk = achk; e.addr = addr; e.din = din;
    e.done = done; e.pv = pv; e.pd = pd; e.mt = mt; e.ms = ms; e.cp = cp;
    e.len = 5'(len); e.err = err;
    return e;
  endfunction

  // Expand one accepted command into expected cycles and advance the model.
  task automatic expand(input int kind, input logic [3:0] d);
    logic cp;
    case (kind)
      K_CLEAR: begin
        for (int k = 0; k < 16; k++)
          exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 4'(k), 4'd0, 1'b0, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
        m_len = 0; m_cidx = 0; m_pd = 4'd0; m_err = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
      end
      K_APPEND: begin
        if (m_len == 16) begin
          m_err = 1'b1;
        end else begin
          exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 4'(m_len), d, 1'b0, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
          m_seq[m_len] = d;
          m_len++;
          m_cidx = 0;
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
      end
      K_PLAY: begin
        for (int i = 0; i < m_len; i++) begin
          exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 4'(i), 4'd0, 1'b0, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
          exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
          m_pd = m_seq[i];
          for (int h = 0; h < HOLD; h++)
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, (h == 0), m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
      end
      default: begin
        if (m_cidx >= m_len) begin
          m_err = 1'b1;
          exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
        end else begin
          exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 4'(m_cidx), 4'd0, 1'b0, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
          exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err));
          if (d == m_seq[m_cidx]) begin
            m_cidx++;
            cp = (m_cidx == m_len);
            if (cp) m_cidx = 0;
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, m_pd, 1'b1, 1'b0, cp, m_len, m_err));
          end else begin
            m_cidx = 0;
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, m_pd, 1'b0, 1'b1, 1'b0, m_len, m_err));
          end
        end
      end
    endcase
  endtask

  // Per-cycle compare against the model, plus event logging for literal checks.
  always @(posedge clock) begin
    exp_t e;
    #1;
    cyc++;
    if (bus.ram_we) we_cnt++;
    if (bus.check_complete) comp_cnt++;
    if (bus.play_valid) begin
      pv_data_q.push_back(bus.play_data);
      pv_cyc_q.push_back(cyc);
    end
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, m_pd, 1'b0, 1'b0, 1'b0, m_len, m_err);
      check("busy", 32'(bus.busy), 32'(e.busy));
      check("ram_we", 32'(bus.ram_we), 32'(e.we));
      check("ram_din", 32'(bus.ram_din), 32'(e.din));
      if (e.achk) check("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
      check("done", 32'(bus.done), 32'(e.done));
      check("play_valid", 32'(bus.play_valid), 32'(e.pv));
      check("play_data", 32'(bus.play_data), 32'(e.pd));
      check("check_match", 32'(bus.check_match), 32'(e.mt));
      check("check_miss", 32'(bus.check_miss), 32'(e.ms));
      check("check_complete", 32'(bus.check_complete), 32'(e.cp));
      check("seq_len", 32'(bus.seq_len), 32'(e.len));
      check("full", 32'(bus.full), 32'(e.len == 5'd16));
      check("error", 32'(bus.error), 32'(e.err));
    end
  end

  // Drive one command for a single edge; caller is at a falling edge.
  task automatic issue(input int kind, input logic [3:0] d, input logic [3:0] extra);
    bus.cmd_clear  = (kind == K_CLEAR)  | extra[0];
    bus.cmd_append = (kind == K_APPEND) | extra[1];
    bus.cmd_play   = (kind == K_PLAY)   | extra[2];
    bus.cmd_check  = (kind == K_CHECK)  | extra[3];
    bus.cmd_data   = d;
    if (chk_en) expand(kind, d);
    @(negedge clock);
    bus.cmd_clear = 1'b0; bus.cmd_append = 1'b0; bus.cmd_play = 1'b0; bus.cmd_check = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL command_timeout: got %0d pending cycles, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 16; i++) mem[i] = 4'hF;
    reset = 1'b1;
    bus.cmd_clear = 1'b0; bus.cmd_append = 1'b0; bus.cmd_play = 1'b0; bus.cmd_check = 1'b0;
    bus.cmd_data = 4'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_seq_len", 32'(bus.seq_len), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_play_data", 32'(bus.play_data), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clock);

    // Clear: sixteen writes.
    we_cnt = 0;
    issue(K_CLEAR, 4'd0, 4'b0000); wait_idle();
    check("clear_we_cycles", 32'(we_cnt), 32'd16);

    // Three appends, back to back through the done cycles.
    issue(K_APPEND, 4'h3, 4'b0000); wait_idle();
    issue(K_APPEND, 4'hA, 4'b0000); wait_idle();
    issue(K_APPEND, 4'h5, 4'b0000); wait_idle();
    check("append_seq_len", 32'(bus.seq_len), 32'd3);

    // Playback with an append attempted while busy.
    pv_data_q.delete(); pv_cyc_q.delete();
    issue(K_PLAY, 4'd0, 4'b0000);
    bus.cmd_append = 1'b1; bus.cmd_data = 4'h9;
    repeat (5) @(negedge clock);
    bus.cmd_append = 1'b0;
    wait_idle();
    check("play_pulses", 32'(pv_data_q.size()), 32'd3);
    if (pv_data_q.size() >= 3) begin
      check("play_d0", 32'(pv_data_q[0]), 32'h3);
      check("play_d1", 32'(pv_data_q[1]), 32'hA);
      check("play_d2", 32'(pv_data_q[2]), 32'h5);
      check("play_gap01", 32'(pv_cyc_q[1] - pv_cyc_q[0]), 32'd6);
      check("play_gap12", 32'(pv_cyc_q[2] - pv_cyc_q[1]), 32'd6);
    end
    check("play_seq_len", 32'(bus.seq_len), 32'd3);

    // Checks: a full matching round (check wins over play), then hit, miss, restart.
    comp_cnt = 0;
    issue(K_CHECK, 4'h3, 4'b0000); wait_idle();
    issue(K_CHECK, 4'hA, 4'b0100); wait_idle();
    issue(K_CHECK, 4'h5, 4'b0000); wait_idle();
    check("complete_pulses", 32'(comp_cnt), 32'd1);
    issue(K_CHECK, 4'h3, 4'b0000); wait_idle();
    issue(K_CHECK, 4'h7, 4'b0000); wait_idle();
    issue(K_CHECK, 4'h3, 4'b0000); wait_idle();

    // Fill to sixteen, overflow on the seventeenth, clear the error.
    issue(K_CLEAR, 4'd0, 4'b0000); wait_idle();
    for (int i = 0; i < 16; i++) begin
      issue(K_APPEND, 4'(i), 4'b0000); wait_idle();
    end
    check("fill_full", 32'(bus.full), 32'd1);
    we_cnt = 0;
    issue(K_APPEND, 4'hC, 4'b0000); wait_idle();
    check("overflow_error", 32'(bus.error), 32'd1);
    check("overflow_no_write", 32'(we_cnt), 32'd0);
    check("overflow_seq_len", 32'(bus.seq_len), 32'd16);
    issue(K_CLEAR, 4'd0, 4'b0000); wait_idle();
    check("clear_error", 32'(bus.error), 32'd0);

    // Reset in the middle of a clear.
    issue(K_APPEND, 4'h6, 4'b0000); wait_idle();
    chk_en = 1'b0;
    issue(K_CLEAR, 4'd0, 4'b0000);
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(posedge clock); #1;
      if (bus.ram_we && bus.ram_addr == 4'd6) found = 1'b1;
    end
    check("abort_reached_addr6", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_we", 32'(bus.ram_we), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_seq_len", 32'(bus.seq_len), 32'd0);
    we_cnt = 0;
    @(negedge clock);
    reset = 1'b0;
    m_len = 0; m_cidx = 0; m_pd = 4'd0; m_err = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_no_writes", 32'(we_cnt), 32'd0);
    pv_data_q.delete(); pv_cyc_q.delete();
    issue(K_PLAY, 4'd0, 4'b0000); wait_idle();
    check("empty_play_pulses", 32'(pv_data_q.size()), 32'd0);
    issue(K_CHECK, 4'h2, 4'b0000); wait_idle();
    check("empty_check_error", 32'(bus.error), 32'd1);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_seq_controller.md
Name: ram_seq_controller

Overview:
Sequencer for the 16x4 synchronous sequence RAM of the PULOdoSAPO game datapath. Accepts clear, append, playback and check commands from the game FSM. Drives the RAM's write_enable, address and data_in, and consumes its registered data_out. Tracks sequence length and the player's check position, and reports match, miss, completion and error.

Parameters:
HOLD_CYCLES, 4, cycles play_data is held after each play_valid pulse (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_clear  in  1  command: zero RAM and state
cmd_append  in  1  command: write cmd_data at end of sequence
cmd_play  in  1  command: replay stored sequence
cmd_check  in  1  command: compare cmd_data with next expected entry
cmd_data  in  4  data for append/check, sampled with command
ram_we  out  1  to RAM write_enable
ram_addr  out  4  to RAM address
ram_din  out  4  to RAM data_in
ram_dout  in  4  from RAM data_out (registered, 1-cycle read latency, read-before-write)
busy  out  1  command in progress; commands ignored while high
done  out  1  one-cycle pulse: command finished
seq_len  out  5  stored entries, 0..16
full  out  1  seq_len == 16
play_valid  out  1  one-cycle pulse: new play_data
play_data  out  4  current playback entry
check_match  out  1  pulse with done: check hit
check_miss  out  1  pulse with done: check miss
check_complete  out  1  pulse with done: last entry matched
error  out  1  sticky: append when full, or check with nothing remaining

Behaviour:
- Reset (async): state IDLE; seq_len=0, check_idx=0, play_data=0, error=0; all pulses and busy=0. RAM contents are not cleared; seq_len=0 makes them logically empty.
- ram_we/ram_addr/ram_din decode from state registers only. In all states except CLEAR/APPEND: ram_we=0, ram_din=0.
- Commands are sampled at a rising edge only in IDLE. Priority when several are high: clear > append > check > play. cmd_data is latched at acceptance.
- busy=1 from the cycle after acceptance through the last command cycle. The done cycle has busy=0, and a new command can be sampled at the edge ending it.
- CLEAR: 16 cycles, ram_we=1, ram_addr=0..15 ascending, ram_din=0. Then seq_len=0, check_idx=0, play_data=0, error=0, done.
- APPEND, not full: 1 cycle, ram_we=1, ram_addr=seq_len[3:0], ram_din=data. Then seq_len+1, check_idx=0, done. Accept at edge E0 -> write cycle -> done in the second cycle after E0.
- APPEND, full: no write, error=1, done; seq_len unchanged.
- PLAY, seq_len=0: done in the cycle after acceptance; no play_valid.
- PLAY, per entry i=0..seq_len-1, states READ, WAIT, HOLD:
  - READ: ram_addr=i.
  - WAIT: ram_dout valid; at the end of WAIT, play_data<=ram_dout.
  - HOLD: HOLD_CYCLES cycles; play_valid=1 in the first HOLD cycle only.
  - Period per entry = 2+HOLD_CYCLES cycles. After the last HOLD: done.
  - play_data holds its last value until the next play, clear or reset.
- CHECK, check_idx >= seq_len: no read, error=1, done; no match/miss.
- CHECK, otherwise: READ (ram_addr=check_idx), then WAIT, then compare ram_dout with latched data and go to done.
  - Match: check_match=1; check_idx+1. If the new check_idx == seq_len, check_complete=1 and check_idx=0.
  - Mismatch: check_miss=1, check_idx=0.
- Arithmetic: seq_len is 5-bit and saturates at 16 via the full check. check_idx is 5-bit and never exceeds seq_len. ram_addr is a 4-bit truncation.
- Command inputs during busy are dropped, not queued.
- Reset mid-command aborts immediately; no further RAM writes.

Test Plan:
- Reset, clear -> ram_we=1 for exactly 16 cycles with addr 0..15 and din 0, then done; seq_len=0, busy=0.
- Append 4'h3, 4'hA, 4'h5 -> one ram_we cycle each at addr 0,1,2; seq_len=3; done 2 cycles after each acceptance.
- Play with HOLD_CYCLES=4 after the above -> play_valid pulses 6 cycles apart with play_data 3, A, 5; done after the 3rd hold; cmd_append during playback ignored, seq_len stays 3.
- Check 3, A, 5 -> check_match on each, check_complete with the third; then check 3, 7 -> match, then miss, check_idx back to 0.
- Append 17 times after clear -> seq_len=16, full=1; the 17th sets error=1 with no ram_we; clear -> error=0.
- Assert reset during CLEAR at address 6 -> ram_we drops asynchronously, busy=0, seq_len=0; next play gives immediate done with no play_valid.
